// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// queues {inst, pc, misaligned} entries toward decode through a small FIFO.
package cotm32_pkg;
  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;
endpackage

module fetch_unit
  import cotm32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              FIFO_DEPTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [XLEN-1:0]       o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  input  logic                  i_redirect,
  input  logic [XLEN-1:0]       i_redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [XLEN-1:0]       o_pc,
  output logic [XLEN-1:0]       o_pc_plus4,
  output logic                  o_misaligned
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013);

  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0]       pc_mem   [FIFO_DEPTH];
  logic                  mis_mem  [FIFO_DEPTH];

  logic push;
  logic pop;
  logic pc_misaligned;

  assign pc_misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign pop           = o_valid && i_ready;

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state -- a misaligned fetch parks the unit until redirected
  always_comb begin
    state_d = state_q;
    if (i_redirect) begin
      state_d = FETCH;
    end else if (push && pc_misaligned) begin
      state_d = HALT;
    end
  end

  // FSM: outputs -- a full FIFO still accepts a push when decode pops the same cycle
  always_comb begin
    push = 1'b0;
    if (state_q == FETCH && !i_redirect &&
        (count_q < CNT_W'(FIFO_DEPTH) || pop)) begin
      push = 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (!pc_misaligned) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_VECTOR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= pc_misaligned ? NOP_INST : i_imem_inst;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      mis_mem[wr_ptr_q]  <= pc_misaligned;
    end
  end

  assign o_imem_addr  = fetch_pc_q;
  assign o_valid      = (count_q != '0);
  assign o_inst       = o_valid ? inst_mem[rd_ptr_q] : '0;
  assign o_pc         = o_valid ? pc_mem[rd_ptr_q] : '0;
  assign o_pc_plus4   = o_valid ? (pc_mem[rd_ptr_q] + XLEN'(4)) : '0;
  assign o_misaligned = o_valid && mis_mem[rd_ptr_q];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction memory.
- Owns the program counter, drives the memory read address, and captures the combinationally returned instruction word.
- Buffers each fetched word with its PC in a small FIFO and hands it to decode over a valid/ready handshake.
- Handles control-flow redirects from execute (branch, jump, trap) with a full flush, and flags misaligned fetch targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned and within instruction memory.
- FIFO_DEPTH, 2: fetch buffer entries; power of two, ≥2.
- XLEN and INST_WIDTH come from cotm32_pkg (32 each); they are not overridable here.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- o_imem_addr  output  XLEN  current fetch PC, driven to the instruction memory address input.
- i_imem_inst  input  INST_WIDTH  instruction word returned combinationally for o_imem_addr.
- i_redirect  input  1  execute requests a PC change this cycle.
- i_redirect_pc  input  XLEN  redirect target; sampled only when i_redirect=1.
- o_valid  output  1  head FIFO entry valid toward decode.
- i_ready  input  1  decode accepts the head entry.
- o_inst  output  INST_WIDTH  head instruction.
- o_pc  output  XLEN  PC of the head instruction.
- o_pc_plus4  output  XLEN  o_pc+4, modulo 2^XLEN.
- o_misaligned  output  1  head entry is an instruction-address-misaligned fault.

Behaviour:
- Registers:
  - fetch_pc
  - state ∈ {FETCH, HALT}
  - FIFO storage of {inst, pc, misaligned}
  - rd_ptr, wr_ptr, count (width $clog2(FIFO_DEPTH)+1)
- Async reset (i_rst=1): fetch_pc=RESET_VECTOR, state=FETCH, count=0, pointers=0.
  - Output reset values: o_valid=0, o_inst=0, o_pc=0, o_pc_plus4=0, o_misaligned=0.
  - o_imem_addr=RESET_VECTOR.
  - Reset asserted mid-operation discards all buffered entries immediately.
- o_imem_addr = fetch_pc at all times, combinational from the register.
- pop = o_valid && i_ready.
- push is asserted when all hold: state==FETCH, i_redirect==0, and (count<FIFO_DEPTH or pop).
  - Simultaneous push and pop at full is allowed; count is unchanged.
- On push, enqueue the entry and update fetch_pc/state:
  - Aligned fetch_pc (fetch_pc[1:0]==0): enqueue {i_imem_inst, fetch_pc, 0}; fetch_pc <= fetch_pc+4, wrapping modulo 2^XLEN.
  - Misaligned fetch_pc (fetch_pc[1:0]!=0): enqueue {32'h0000_0013 (NOP), fetch_pc, 1}; fetch_pc holds; state <= HALT.
- HALT: no pushes; existing entries still drain. Only a redirect or reset leaves HALT.
- Redirect (i_redirect=1) has highest priority, below reset:
  - Next edge: count=0, pointers=0, fetch_pc <= i_redirect_pc, state <= FETCH.
  - No push that cycle.
  - A pop in the same cycle is ignored by the FIFO; decode is flushed by the same signal.
  - Fetch timing: redirect seen at edge N; target is fetched (pushed) at edge N+1; o_valid=1 with the target word in the cycle after edge N+1.
- Output timing:
  - o_valid = (count!=0), registered-derived with no combinational path from i_ready.
  - o_inst, o_pc, o_misaligned reflect the head entry.
  - When o_valid=0, the data outputs are don't-care to decode; the bench checks them only when valid.
- Throughput:
  - Steady state with i_ready=1: one instruction per cycle after a 1-cycle initial latency.
  - Reset release → first o_valid occurs one cycle after the first edge with i_rst=0.
- Stall: while i_ready=0, the FIFO fills to FIFO_DEPTH, then fetch_pc freezes.
  - No word is dropped or duplicated across a stall.
- PC wrap: 32'hFFFF_FFFC+4 → 32'h0000_0000 with no flag. Out-of-range addresses are not this block's concern.

Test Plan:
- Sequential fetch: reset with RESET_VECTOR=0, i_ready=1, memory holds 0x11,0x22,0x33 at words 0,1,2 → o_valid rises one cycle after reset release; outputs (0x11,pc 0), (0x22,pc 4), (0x33,pc 8) on consecutive cycles; o_pc_plus4 = 4, 8, 12.
- Backpressure: i_ready=0 for 5 cycles after first valid → count saturates at 2 and o_imem_addr stops at 8; after release, pc 0, 4, 8, 12 are delivered in order with no gaps or duplicates.
- Redirect flush: with 2 entries buffered, pulse i_redirect with i_redirect_pc=0x40 while i_ready=1 → next cycle o_valid=0; following cycle o_pc=0x40 with the word at 0x40; the flushed PCs never appear.
- Misaligned target: redirect to 0x42 → one entry with o_pc=0x42, o_misaligned=1, o_inst=0x13; o_imem_addr holds 0x42 with no further valids. A later redirect to 0x80 resumes normal fetch from 0x80.
- Full push/pop plus redirect collision: FIFO full, i_ready=1 every cycle → count stays 2 and throughput stays 1/cycle. A redirect asserted in the same cycle as a pop → FIFO empties and the popped entry is not re-presented.
- Async reset mid-stream: assert i_rst between clock edges while o_valid=1 → o_valid=0 and o_imem_addr=RESET_VECTOR immediately, without waiting for a clock edge; fetch restarts from RESET_VECTOR after release.
